// File: rtl/uart_arb_pkg.sv
// Shared types and sizing helpers for the UART TX arbiter
// and its round-robin picker.
package uart_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int HOLD_TIMEOUT_DEF = 1023;

  // Index width; a single requester still needs one bit.
  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Idle counter width; it only ever counts up to the timeout.
  function automatic int cnt_w(input int t);
    return $clog2(t + 1);
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin find-first.
// Ports: req (candidates), ptr (last winner) -> found, idx.
module uart_rr_picker #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  function automatic int wrap(
    input logic [W-1:0] p,
    input int           k
  );
    return (int'(p) + k) % N;
  endfunction

  // Walk from the farthest slot down to ptr+1 so the
  // nearest candidate after ptr is the final assignment.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[wrap(ptr, k)]) begin
        found = 1'b1;
        idx   = W'(wrap(ptr, k));
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin share of one UART TX byte port.
// Ports: clk/resetn; req_valid/req_data/req_last/req_ready per
// requester; tx_valid/tx_data/tx_ready toward the serializer;
// grant_id, busy, timeout_pulse status.
// Build option UART_ARB_STATS_EN adds stat_clr, stat_bytes and
// stat_timeouts.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int HOLD_TIMEOUT = HOLD_TIMEOUT_DEF,
  parameter int GRANT_W      = grant_w(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic [GRANT_W-1:0]   grant_id,
  output logic                 busy,
  output logic                 timeout_pulse
`ifdef UART_ARB_STATS_EN
  ,
  input  logic                  stat_clr,
  output logic [32*NUM_REQ-1:0] stat_bytes,
  output logic [7:0]            stat_timeouts
`endif
);

  localparam int CNT_W = cnt_w(HOLD_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(HOLD_TIMEOUT - 1);

  arb_state_e         state_q, state_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [GRANT_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tmo_q, tmo_d;

  logic               pick_found;
  logic [GRANT_W-1:0] pick_idx;

  logic [NUM_REQ-1:0] own_sel;
  logic               own_valid;
  logic               own_last;
  logic [7:0]         own_data;
  logic               hs;
  logic               hs_last;
  logic               hs_more;
  logic               expire;
  logic               tick;

  uart_rr_picker #(
    .N (NUM_REQ),
    .W (GRANT_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Owner mux; only the granted lane is ever looked at.
  always_comb begin
    own_sel   = '0;
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == GRANT_W'(i)) begin
        own_sel[i] = 1'b1;
        own_valid  = req_valid[i];
        own_last   = req_last[i];
        own_data   = req_data[8*i +: 8];
      end
    end
  end

  // Idle means the owner has nothing offered; a stalled
  // serializer with a byte waiting is not idle.
  always_comb begin
    hs      = own_valid & tx_ready;
    hs_last = hs & own_last;
    hs_more = hs & ~own_last;
    expire  = ~own_valid & (cnt_q == CNT_LAST);
    tick    = ~own_valid & (cnt_q != CNT_LAST);
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    tmo_d     = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        tx_valid  = own_valid;
        tx_data   = own_data;
        req_ready = own_sel & {NUM_REQ{tx_ready}};
        unique case (1'b1)
          hs_last: begin
            state_d  = IDLE;
            rr_ptr_d = grant_q;
            cnt_d    = '0;
          end
          hs_more: cnt_d = '0;
          expire: begin
            state_d  = IDLE;
            rr_ptr_d = grant_q;
            tmo_d    = 1'b1;
            cnt_d    = '0;
          end
          tick:    cnt_d = cnt_q + CNT_W'(1);
          default: cnt_d = cnt_q;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= GRANT_W'(NUM_REQ - 1);
      cnt_q    <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
    end
  end

  assign grant_id      = grant_q;
  assign busy          = (state_q == LOCKED);
  assign timeout_pulse = tmo_q;

`ifdef UART_ARB_STATS_EN
  logic [32*NUM_REQ-1:0] stat_bytes_q, stat_bytes_d;
  logic [7:0]            stat_timeouts_q, stat_timeouts_d;
  logic                  acc;

  always_comb begin
    acc             = (state_q == LOCKED) & hs;
    stat_bytes_d    = stat_bytes_q;
    stat_timeouts_d = stat_timeouts_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc && own_sel[i]) begin
        stat_bytes_d[32*i +: 32] =
          stat_bytes_q[32*i +: 32] + 32'd1;
      end
    end
    if (tmo_d && stat_timeouts_q != 8'hFF) begin
      stat_timeouts_d = stat_timeouts_q + 8'd1;
    end
    // Clear beats a coincident increment.
    if (stat_clr) begin
      stat_bytes_d    = '0;
      stat_timeouts_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_bytes_q    <= '0;
      stat_timeouts_q <= '0;
    end else begin
      stat_bytes_q    <= stat_bytes_d;
      stat_timeouts_q <= stat_timeouts_d;
    end
  end

  assign stat_bytes    = stat_bytes_q;
  assign stat_timeouts = stat_timeouts_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester byte
// drivers, a message-level reference model, one monitor.
module tb_uart_tx_arbiter;

  localparam int NREQ = 2;
  localparam int HOLD = 16;
  localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [7:0] gap;
  } item_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic                clk;
  logic                resetn;
  logic [NREQ-1:0]     req_valid;
  logic [8*NREQ-1:0]   req_data;
  logic [NREQ-1:0]     req_last;
  logic [NREQ-1:0]     req_ready;
  logic                tx_valid;
  logic [7:0]          tx_data;
  logic                tx_ready;
  logic [GW-1:0]       grant_id;
  logic                busy;
  logic                timeout_pulse;
`ifdef UART_ARB_STATS_EN
  logic                stat_clr;
  logic [32*NREQ-1:0]  stat_bytes;
  logic [7:0]          stat_timeouts;
`endif

  uart_tx_arbiter #(
    .NUM_REQ      (NREQ),
    .HOLD_TIMEOUT (HOLD)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .grant_id      (grant_id),
    .busy          (busy),
    .timeout_pulse (timeout_pulse)
`ifdef UART_ARB_STATS_EN
    ,
    .stat_clr      (stat_clr),
    .stat_bytes    (stat_bytes),
    .stat_timeouts (stat_timeouts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver-side lane values.
  logic       dv [NREQ];
  logic [7:0] dd [NREQ];
  logic       dl [NREQ];

  always_comb begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]       = dv[i];
      req_data[8*i +: 8] = dd[i];
      req_last[i]        = dl[i];
    end
  end

  item_t items [NREQ][$];
  exp_t  exp_q [NREQ][$];
  int    sent  [NREQ];
  int    epoch;
  int    rmode;
  int    n_vec;
  int    n_err;

  // Reference model state.
  bit    m_busy;
  int    m_owner;
  int    m_last;
  int    m_cnt;
  bit    m_pulse;
  int    m_bytes [NREQ];
  int    m_tmo;

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(
    input int         r,
    input logic [7:0] d,
    input logic       l,
    input int         g
  );
    item_t it;
    it.data = d;
    it.last = l;
    it.gap  = 8'(g);
    items[r].push_back(it);
  endtask

  task automatic drive(input int r);
    item_t it;
    exp_t  e;
    int    ep;
    bit    done;
    forever begin
      if (items[r].size() == 0) begin
        dv[r] = 1'b0;
        cyc();
      end else begin
        it    = items[r].pop_front();
        ep    = epoch;
        dv[r] = 1'b0;
        repeat (int'(it.gap)) cyc();
        if (ep == epoch) begin
          dv[r]  = 1'b1;
          dd[r]  = it.data;
          dl[r]  = it.last;
          e.data = it.data;
          e.last = it.last;
          exp_q[r].push_back(e);
          done = 1'b0;
          while (!done && ep == epoch) begin
            @(negedge clk);
            if (ep == epoch && resetn && req_ready[r])
              done = 1'b1;
            cyc();
          end
          if (done) sent[r]++;
          else dv[r] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    tx_ready = 1'b1;
    forever begin
      cyc();
      case (rmode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = 1'b0;
        default: tx_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // First pending requester after the previous owner.
  function automatic int rr_pick(input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (dv[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [63:0] onehot(input int o);
    logic [63:0] v;
    v = 64'd1;
    return v << o;
  endfunction

  initial begin : monitor
    int   o;
    int   p;
    bit   nxt;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        m_busy  = 1'b0;
        m_last  = NREQ - 1;
        m_cnt   = 0;
        m_pulse = 1'b0;
        m_tmo   = 0;
        for (int i = 0; i < NREQ; i++) begin
          m_bytes[i] = 0;
          exp_q[i].delete();
        end
        chk("rst_busy", busy, 0);
        chk("rst_txv", tx_valid, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_pulse", timeout_pulse, 0);
      end else begin
        chk("timeout_pulse", timeout_pulse, m_pulse);
        nxt = 1'b0;
        if (!m_busy) begin
          chk("idle_busy", busy, 0);
          chk("idle_txv", tx_valid, 0);
          chk("idle_ready", req_ready, 0);
          p = rr_pick(m_last);
          if (p >= 0) begin
            m_busy  = 1'b1;
            m_owner = p;
            m_cnt   = 0;
          end
        end else begin
          o = m_owner;
          chk("lock_busy", busy, 1);
          chk("grant_id", grant_id, o);
          chk("tx_valid", tx_valid, dv[o]);
          chk("req_ready", req_ready,
              tx_ready ? onehot(o) : 64'd0);
          if (dv[o]) chk("tx_data_pass", tx_data, dd[o]);
          if (dv[o] && tx_ready) begin
            if (exp_q[o].size() == 0) begin
              chk("sb_empty", 1, 0);
            end else begin
              e = exp_q[o].pop_front();
              chk("sb_data", tx_data, e.data);
              m_bytes[o]++;
              m_cnt = 0;
              if (e.last) begin
                m_busy = 1'b0;
                m_last = o;
              end
            end
          end else if (!dv[o]) begin
            m_cnt++;
            if (m_cnt == HOLD) begin
              m_busy = 1'b0;
              m_last = o;
              m_cnt  = 0;
              nxt    = 1'b1;
              if (m_tmo < 255) m_tmo++;
            end
          end
        end
        m_pulse = nxt;
      end
    end
  end

  function automatic bit all_idle();
    if (m_busy) return 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (items[i].size() != 0) return 1'b0;
      if (exp_q[i].size() != 0) return 1'b0;
      if (dv[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    cyc();
    while (n < 20000 && !all_idle()) begin
      cyc();
      n++;
    end
    n_vec++;
    if (n >= 20000) begin
      n_err++;
      $display("FAIL %s: drain not reached in %0d cycles",
               nm, n);
    end
    repeat (3) cyc();
  endtask

  task automatic wait_sent(input int r, input int tgt);
    int n;
    n = 0;
    while (n < 5000 && sent[r] < tgt) begin
      cyc();
      n++;
    end
    n_vec++;
    if (sent[r] < tgt) begin
      n_err++;
      $display("FAIL wait_sent%0d: got %0d required %0d",
               r, sent[r], tgt);
    end
  endtask

`ifdef UART_ARB_STATS_EN
  task automatic chk_stats(input string nm);
    for (int i = 0; i < NREQ; i++)
      chk(nm, stat_bytes[32*i +: 32], m_bytes[i]);
    chk(nm, stat_timeouts, m_tmo);
  endtask
`endif

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base;
    int r;
    int len;
    int g;
    n_vec  = 0;
    n_err  = 0;
    epoch  = 0;
    rmode  = 0;
    resetn = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      dv[i]   = 1'b0;
      dd[i]   = '0;
      dl[i]   = 1'b0;
      sent[i] = 0;
    end
`ifdef UART_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    for (int i = 0; i < NREQ; i++) begin
      automatic int ri = i;
      fork
        drive(ri);
      join_none
    end
    repeat (4) cyc();
    resetn = 1'b1;
    cyc();

    // Both start together; requester 0 wins first.
    push(0, 8'h01, 1'b0, 0);
    push(0, 8'h02, 1'b0, 0);
    push(0, 8'h03, 1'b1, 0);
    push(1, 8'h11, 1'b0, 0);
    push(1, 8'h12, 1'b1, 0);
    wait_drain("simultaneous");

    // Single requester, "Hi\n".
    push(0, 8'h48, 1'b0, 0);
    push(0, 8'h69, 1'b0, 0);
    push(0, 8'h0A, 1'b1, 0);
    wait_drain("single");

    // Continuous one-byte messages alternate.
    for (int i = 0; i < 4; i++) begin
      push(0, 8'(8'h60 + i), 1'b1, 0);
      push(1, 8'(8'h70 + i), 1'b1, 0);
    end
    wait_drain("fairness");

    // Serializer stalled 500 cycles mid-message.
    base = sent[0];
    push(0, 8'h20, 1'b0, 0);
    push(0, 8'h21, 1'b0, 0);
    push(0, 8'h22, 1'b1, 0);
    wait_sent(0, base + 1);
    rmode = 1;
    repeat (500) cyc();
    rmode = 0;
    wait_drain("backpressure");

    // Owner goes silent after one byte; req0 waits.
    base = sent[1];
    push(1, 8'h41, 1'b0, 0);
    wait_sent(1, base + 1);
    push(0, 8'h30, 1'b0, 0);
    push(0, 8'h31, 1'b1, 0);
    wait_drain("timeout");

    // Random traffic with random serializer stalls.
    rmode = 2;
    for (int k = 0; k < 60; k++) begin
      r   = $urandom_range(0, NREQ - 1);
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        g = ($urandom_range(0, 9) == 0) ? 20 :
            $urandom_range(0, 2);
        push(r, 8'($urandom_range(0, 255)),
             (b == len - 1), g);
      end
    end
    wait_drain("random");
    rmode = 0;
    repeat (2) cyc();

`ifdef UART_ARB_STATS_EN
    @(negedge clk);
    chk_stats("stats_run");
    cyc();
    stat_clr = 1'b1;
    cyc();
    stat_clr = 1'b0;
    for (int i = 0; i < NREQ; i++) m_bytes[i] = 0;
    m_tmo = 0;
    @(negedge clk);
    chk_stats("stats_clr");
    cyc();
`endif

    // Reset while byte 3 of 4 is stuck at the serializer.
    base = sent[0];
    push(0, 8'hA0, 1'b0, 0);
    push(0, 8'hA1, 1'b0, 0);
    push(0, 8'hA2, 1'b0, 4);
    push(0, 8'hA3, 1'b1, 0);
    wait_sent(0, base + 2);
    rmode = 1;
    repeat (8) cyc();
    @(negedge clk);
    chk("pre_rst_txv", tx_valid, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_txv", tx_valid, 0);
    chk("async_busy", busy, 0);
    epoch++;
    for (int i = 0; i < NREQ; i++) items[i].delete();
    repeat (3) cyc();
    rmode  = 0;
    resetn = 1'b1;
`ifdef UART_ARB_STATS_EN
    @(negedge clk);
    chk_stats("stats_rst");
`endif
    cyc();
    push(0, 8'hA0, 1'b0, 0);
    push(0, 8'hA1, 1'b0, 0);
    push(0, 8'hA2, 1'b0, 0);
    push(0, 8'hA3, 1'b1, 0);
    wait_drain("resend");
`ifdef UART_ARB_STATS_EN
    @(negedge clk);
    chk("stat_bytes0", stat_bytes[31:0], 4);
    chk_stats("stats_end");
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
